// File: rtl/jt12_pkg.sv
`default_nettype none
// ============================================================================
// jt12_pkg : shared prescaler mode encoding, command codes and divide ratios
// Rev 1.0
// ============================================================================
package jt12_pkg;

  typedef enum logic [1:0] {
    DIV6 = 2'd0,
    DIV3 = 2'd1,
    DIV2 = 2'd2
  } mode_e;

  localparam logic [7:0] PRESC_N6 = 8'h2D;
  localparam logic [7:0] PRESC_N3 = 8'h2E;
  localparam logic [7:0] PRESC_N2 = 8'h2F;

  localparam logic [2:0] RATIO_N6 = 3'd6;
  localparam logic [2:0] RATIO_N3 = 3'd3;
  localparam logic [2:0] RATIO_N2 = 3'd2;

  function automatic logic [2:0] mode_ratio(input mode_e m);
    case (m)
      DIV3:    mode_ratio = RATIO_N3;
      DIV2:    mode_ratio = RATIO_N2;
      default: mode_ratio = RATIO_N6;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_presc_ctl_if.sv
`default_nettype none
// ============================================================================
// jt12_presc_ctl_if : YM2612-style CPU write bus (strobes, address, data, status)
// Rev 1.0
// ============================================================================
interface jt12_presc_ctl_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output wr_n, output addr, output din, input dout);
  modport slave  (input cs_n, input wr_n, input addr, input din, output dout);
endinterface
`default_nettype wire

// File: rtl/jt12_cen_div.sv
`default_nettype none
// ============================================================================
// jt12_cen_div : clk/6, clk/3, clk/2 clock-enable divider; mode changes only at wrap
// Rev 1.0
// ============================================================================
module jt12_cen_div
  import jt12_pkg::*;
(
  input  wire   clk,
  input  wire   rst_n,
  input  mode_e mode,
  output logic  cen
);

  mode_e      act_q;
  logic [2:0] cnt_q;
  logic [2:0] last_w;

  assign last_w = mode_ratio(act_q) - 3'd1;
  assign cen    = (cnt_q == last_w);

  // The requested mode is adopted only on wrap so every period is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      act_q <= DIV6;
    end else if (cen) begin
      cnt_q <= 3'd0;
      act_q <= mode;
    end else begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jt12_presc_ctl.sv
`default_nettype none
// ============================================================================
// jt12_presc_ctl : bus write decoder, prescaler select, busy flag, internal reset
// Rev 1.0
// ============================================================================
module jt12_presc_ctl
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  wire                    clk,
  input  wire                    rst_n,
  jt12_presc_ctl_if.slave        bus,
  output logic                   set_n6,
  output logic                   set_n3,
  output logic                   set_n2,
  output logic                   cen,
  output logic                   rst_int,
  output logic                   reg_wr,
  output logic                   reg_part,
  output logic [7:0]             reg_addr,
  output logic [7:0]             reg_din
);

  localparam int BW = $clog2(BUSY_CYCLES + 1);

  logic          wr_q;
  logic          wr_last_q;
  logic [1:0]    addr_q;
  logic [7:0]    din_q;
  logic          acc_w;
  mode_e         mode_q;
  mode_e         mode_d;
  logic [BW-1:0] busy_q;
  logic [BW-1:0] busy_d;
  logic [1:0]    rst_sh_q;
  logic          reg_wr_q;
  logic          reg_part_q;
  logic [7:0]    reg_addr_q;
  logic [7:0]    reg_din_q;

  // Bus fields are registered with the strobe so the accepted write uses the
  // values present on the first strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      wr_last_q <= 1'b0;
      addr_q    <= 2'b00;
      din_q     <= 8'h00;
    end else begin
      wr_q      <= ~bus.cs_n & ~bus.wr_n;
      wr_last_q <= wr_q;
      addr_q    <= bus.addr;
      din_q     <= bus.din;
    end
  end

  assign acc_w = wr_q & ~wr_last_q;

  always_comb begin
    mode_d = mode_q;
    if (acc_w && !addr_q[0] && !addr_q[1]) begin
      case (din_q)
        PRESC_N6: mode_d = DIV6;
        PRESC_N3: mode_d = DIV3;
        PRESC_N2: mode_d = DIV2;
        default:  mode_d = mode_q;
      endcase
    end
  end

  // A data write reloads the counter even on the cen that would empty it.
  always_comb begin
    busy_d = busy_q;
    if (acc_w && addr_q[0]) begin
      busy_d = BW'(BUSY_CYCLES);
    end else if (cen && (busy_q != '0)) begin
      busy_d = busy_q - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= DIV6;
      busy_q     <= '0;
      reg_wr_q   <= 1'b0;
      reg_part_q <= 1'b0;
      reg_addr_q <= 8'h00;
      reg_din_q  <= 8'h00;
    end else begin
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      reg_wr_q <= acc_w & addr_q[0];
      if (acc_w && addr_q[0]) begin
        reg_din_q <= din_q;
      end
      if (acc_w && !addr_q[0]) begin
        reg_addr_q <= din_q;
        reg_part_q <= addr_q[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sh_q <= 2'b11;
    end else if (cen) begin
      rst_sh_q <= {rst_sh_q[0], 1'b0};
    end
  end

  jt12_cen_div u_cen_div (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode_q),
    .cen   (cen)
  );

  assign set_n6   = (mode_q == DIV6);
  assign set_n3   = (mode_q == DIV3);
  assign set_n2   = (mode_q == DIV2);
  assign rst_int  = rst_sh_q[1];
  assign reg_wr   = reg_wr_q;
  assign reg_part = reg_part_q;
  assign reg_addr = reg_addr_q;
  assign reg_din  = reg_din_q;
  assign bus.dout = {(busy_q != '0), 7'b0};

endmodule
`default_nettype wire

// File: doc/jt12_presc_ctl.md
# jt12_presc_ctl

CPU-side write decoder and clock-enable generator for the JT12 core: the block that drives the prescaler selection consumed by the internal clock divider. It captures YM2612-style bus writes, decodes the prescaler commands 0x2D/0x2E/0x2F, and produces a glitch-free `cen` pulse train at clk/6, clk/3 or clk/2. It also provides the busy flag, the register-write strobe for the register file, and the stretched internal reset.

## Interface
- `BUSY_CYCLES`, default 32: number of `cen` pulses `busy` stays high after a data write.
- `clk` in 1: master clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs_n` in 1: chip select, active low.
- `wr_n` in 1: write strobe, active low.
- `addr` in 2: bit0 = 0 selects an address write, 1 selects a data write; bit1 = part (0 = ports 0/1, 1 = ports 2/3).
- `din` in 8: CPU write data.
- `dout` out 8: status `{busy, 7'b0}`.
- `set_n6`, `set_n3`, `set_n2` out 1 each: one-hot prescaler selection.
- `cen` out 1: one-`clk`-wide clock-enable pulse.
- `rst_int` out 1: internal synchronous reset, active high.
- `reg_wr` out 1: one-`clk` pulse, register-file data write.
- `reg_part` out 1: part latched with the last address write.
- `reg_addr` out 8: last latched address.
- `reg_din` out 8: data for `reg_wr`.

## Operation
- **Write detect:** `wr_q` is `~cs_n & ~wr_n`, registered. A write is accepted on the first `clk` where it is 1 and was 0 the cycle before. Holding the strobe low never repeats a write.
- **Address write (addr[0]=0):**
  - Latch `reg_addr <= din` and `reg_part <= addr[1]`.
  - If `addr[1]=0` and `din` is 0x2D, select DIV6; 0x2E selects DIV3; 0x2F selects DIV2.
  - Any other address leaves the mode unchanged.
  - Prescaler writes do not assert `reg_wr` or `busy`.
- **Data write (addr[0]=1):**
  - `reg_din <= din`, and `reg_wr` pulses one cycle later.
  - `busy` goes high and the busy counter loads `BUSY_CYCLES`.
  - A data write while busy is still accepted and reloads the counter.
- **Mode to outputs:** DIV6 gives `set_n6`=1; DIV3 gives `set_n3`=1; DIV2 gives `set_n2`=1. Exactly one is high at all times.
- **Divider:** 3-bit counter counting 0..N-1 with N = 6/3/2.
  - `cen`=1 on the cycle the counter equals N-1.
  - A pending mode is applied only when the counter wraps to 0, so no runt or double pulse is ever produced.
- **Busy counter:** decrements on each `cen` while nonzero; `busy` = (count != 0).
- **rst_int:** 2-stage shift register clocked by `cen`. It reads 1 during reset and clears on the 2nd `cen` after `rst_n` rises.

## Timing
- **Reset values:**
  - Mode DIV6, `set_n6`=1, `set_n3`=`set_n2`=0.
  - `cen`=0, divider count=0, `busy`=0, `dout`=0x00.
  - `rst_int`=1, `reg_wr`=0, `reg_addr`=0x00, `reg_din`=0x00, `reg_part`=0.
- **Cen cadence:** first `cen` after reset release arrives on the 6th rising `clk` edge (count reaches 5).
- **Write latency:** strobe sampled at edge k; `reg_addr`/`reg_din` update at k+1; `reg_wr` is high during cycle k+1→k+2.
- **Mode latency:** `set_n*` outputs update at k+1. The `cen` period switches at the next divider wrap, after at most N_old cycles.
- **Busy:** rises at k+1 and falls on the `cen` that brings the count to 0, i.e. after exactly `BUSY_CYCLES` `cen` pulses.
- **Simultaneous events:** a data write on the same cycle as the busy count reaching 0 means the reload wins and `busy` stays 1.
- **Reset mid-operation:** `rst_n` low clears everything asynchronously, including a pending mode change and a `reg_wr` in flight.

## Structure
- **Shared package `jt12_pkg`:**
  - Mode enum {DIV6, DIV3, DIV2}.
  - Constants `PRESC_N6`=8'h2D, `PRESC_N3`=8'h2E, `PRESC_N2`=8'h2F.
  - Divider ratios 6/3/2.
- **Sub-module `jt12_cen_div`:** divider plus pending-mode register. Inputs `clk`, `rst_n`, `mode`; output `cen`.
- **Top level:** bus capture, address/data latches, busy counter, `rst_int`.

## Test plan
- **Reset cadence:** release reset with no writes → `cen` every 6 clks, first at clk 6; `rst_int` falls at clk 12; `set_n6`=1.
- **DIV3 switch:** address write 0x2E with addr=2'b00 → `set_n3`=1 next cycle; `cen` spacing becomes 3 after the current 6-cycle period completes; no pulse gap shorter than 3.
- **Mode sequence:** write 0x2F, then 0x2D → spacing goes 6→2→6; `set_n*` one-hot at every cycle.
- **Busy:** address write 0x30, then data write 0x71 → `reg_wr` pulses once with `reg_addr`=0x30 and `reg_din`=0x71; `dout`=0x80 for exactly 32 `cen` pulses, then 0x00.
- **Held strobe and part:** hold `wr_n` low for 20 clks → exactly one write. Address write 0x2D with addr=2'b10 → mode unchanged and `reg_part`=1.
- **Reset mid-operation:** assert `rst_n` low mid-busy and mid-pending mode change → all outputs at reset values immediately; `busy`=0; mode DIV6.
